// File: rtl/vc_multi_drop_unit_pkg.sv
// Shared definitions for the drop/flush unit family: steering modes and
// the pending-counter width helper.
package vc_multi_drop_unit_pkg;

    // Steering mode of a drop unit in a given cycle
    typedef enum logic {
        DROP_MODE_PASS    = 1'b0,
        DROP_MODE_DISCARD = 1'b1
    } drop_mode_e;

    // Bits needed to hold a count from 0 to max_drops inclusive
    function automatic int drop_cnt_nbits(input int max_drops);
        return (max_drops < 1) ? 1 : $clog2(max_drops + 1);
    endfunction

endpackage

// File: rtl/vc_multi_drop_unit_if.sv
// Val/rdy stream pair seen by a drop unit: the input stream it may discard
// from and the output stream it forwards to.
interface vc_multi_drop_unit_if #(
    parameter int p_msg_nbits = 1
);
    logic [p_msg_nbits-1:0] in_msg;
    logic                   in_val;
    logic                   in_rdy;
    logic [p_msg_nbits-1:0] out_msg;
    logic                   out_val;
    logic                   out_rdy;

    // Environment side: produces the input stream, consumes the output stream
    modport master (
        output in_msg, in_val, out_rdy,
        input  in_rdy, out_msg, out_val
    );

    // Drop unit side
    modport slave (
        input  in_msg, in_val, out_rdy,
        output in_rdy, out_msg, out_val
    );
endinterface

// File: rtl/vc_multi_drop_unit_sat_counter.sv
// Saturating up/down counter holding the number of outstanding drops.
// clear has priority; an increment that would pass p_max holds at p_max and
// raises sat for that cycle.
module vc_multi_drop_unit_sat_counter
    import vc_multi_drop_unit_pkg::*;
#(
    parameter int p_max   = 4,
    parameter int p_nbits = drop_cnt_nbits(p_max)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    input  logic               clear,
    output logic [p_nbits-1:0] count,
    output logic               sat
);
    localparam logic [p_nbits:0] max_w = (p_nbits+1)'(p_max);

    logic [p_nbits-1:0] count_reg;
    logic [p_nbits-1:0] count_next;
    logic [p_nbits:0]   sum_wide;
    logic               underflow;

    // Next count: clear, saturate on overshoot, hold on (unexpected) underflow
    always_comb begin
        sum_wide   = {1'b0, count_reg} + (p_nbits+1)'(inc) - (p_nbits+1)'(dec);
        underflow  = dec && !inc && (count_reg == '0);
        sat        = !clear && !underflow && (sum_wide > max_w);
        count_next = sum_wide[p_nbits-1:0];
        if (clear) begin
            count_next = '0;
        end else if (underflow) begin
            count_next = count_reg;
        end else if (sat) begin
            count_next = max_w[p_nbits-1:0];
        end
    end

    // Count register, emptied by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/vc_multi_drop_unit.sv
// Multi-drop unit: discards the next N packets of a val/rdy stream after N
// drop requests. Purely combinational steering around a saturating pending
// counter plus a sticky overflow flag; no data storage, no added latency.
module vc_multi_drop_unit
    import vc_multi_drop_unit_pkg::*;
#(
    parameter  int p_msg_nbits = 1,
    parameter  int p_max_drops = 4,
    localparam int p_cnt_nbits = drop_cnt_nbits(p_max_drops)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   domain,
    input  logic                   drop,
    input  logic                   flush,
    vc_multi_drop_unit_if.slave    io,
    output logic [p_cnt_nbits-1:0] pending,
    output logic                   dropped,
    output logic                   overflow
);
    logic [p_cnt_nbits:0] eff;
    drop_mode_e           mode;
    logic                 cnt_sat;
    logic                 overflow_reg;
    logic                 domain_unused;

    // The security domain is a static label per instance; no logic depends on it
    assign domain_unused = domain;

    // Effective outstanding drops this cycle; a same-cycle drop applies at
    // once, flush cancels everything including a same-cycle drop. While reset
    // is held the unit is forced transparent.
    always_comb begin
        eff  = flush ? '0 : ({1'b0, pending} + (p_cnt_nbits+1)'(drop));
        mode = (reset && (eff != '0)) ? DROP_MODE_DISCARD : DROP_MODE_PASS;
    end

    // Steering: discard swallows the packet, pass is a straight wire
    always_comb begin
        dropped    = (mode == DROP_MODE_DISCARD) && io.in_val;
        io.out_val = (mode == DROP_MODE_PASS) && io.in_val;
        io.in_rdy  = (mode == DROP_MODE_DISCARD) || io.out_rdy;
    end

    for (genvar gi = 0; gi < p_msg_nbits; gi++) begin : g_msg
        assign io.out_msg[gi] = io.in_msg[gi];
    end

    vc_multi_drop_unit_sat_counter #(
        .p_max   (p_max_drops),
        .p_nbits (p_cnt_nbits)
    ) u_pending (
        .clk   (clk),
        .reset (reset),
        .inc   (drop && !flush),
        .dec   (dropped),
        .clear (flush),
        .count (pending),
        .sat   (cnt_sat)
    );

    // Sticky overflow: set when a drop request is lost to saturation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_reg <= 1'b0;
        end else if (cnt_sat) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;
endmodule

// File: tb/tb_vc_multi_drop_unit.sv
// Directed bench for vc_multi_drop_unit: a table of per-cycle vectors plus a
// hand-written asynchronous-reset sequence.
module tb_vc_multi_drop_unit;
    localparam int MSG_W = 8;
    localparam int MAXD  = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             domain;
    logic             drop;
    logic             flush;
    logic [CNT_W-1:0] pending;
    logic             dropped;
    logic             overflow;

    vc_multi_drop_unit_if #(.p_msg_nbits(MSG_W)) bus ();

    vc_multi_drop_unit #(
        .p_msg_nbits (MSG_W),
        .p_max_drops (MAXD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .domain   (domain),
        .drop     (drop),
        .flush    (flush),
        .io       (bus),
        .pending  (pending),
        .dropped  (dropped),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             drop;
        logic             flush;
        logic             in_val;
        logic             out_rdy;
        logic [MSG_W-1:0] msg;
        logic             e_out_val;
        logic             e_in_rdy;
        logic             e_dropped;
        logic [CNT_W-1:0] e_pend;
        logic             e_ovf;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic d, input logic f, input logic v, input logic r, input logic [MSG_W-1:0] m,
                       input logic eov, input logic eir, input logic edr, input logic [CNT_W-1:0] ep, input logic eo);
        vec_t t;
        t.drop = d; t.flush = f; t.in_val = v; t.out_rdy = r; t.msg = m;
        t.e_out_val = eov; t.e_in_rdy = eir; t.e_dropped = edr; t.e_pend = ep; t.e_ovf = eo;
        vecs.push_back(t);
    endtask

    initial begin
        reset = 1'b0; domain = 1'b0; drop = 1'b0; flush = 1'b0;
        bus.in_msg = '0; bus.in_val = 1'b0; bus.out_rdy = 1'b0;

        // 1: pass-through of 0x1..0x8
        for (int i = 1; i <= 8; i++) add(0,0,1,1, MSG_W'(i), 1,1,0, 0,0);
        // 2: three drop requests, then four packets (first three discarded)
        add(1,0,0,1,8'h00, 0,1,0, 0,0);
        add(1,0,0,1,8'h00, 0,1,0, 1,0);
        add(1,0,0,1,8'h00, 0,1,0, 2,0);
        add(0,0,1,0,8'h21, 0,1,1, 3,0);
        add(0,0,1,0,8'h22, 0,1,1, 2,0);
        add(0,0,1,0,8'h23, 0,1,1, 1,0);
        add(0,0,1,1,8'h24, 1,1,0, 0,0);
        // 3: drop with packet in the same cycle, out_rdy low
        add(1,0,1,0,8'h31, 0,1,1, 0,0);
        add(0,0,0,0,8'h32, 0,0,0, 0,0);
        // 4: five drops with no packets saturate at 4 and set overflow
        add(1,0,0,0,8'h00, 0,1,0, 0,0);
        add(1,0,0,0,8'h00, 0,1,0, 1,0);
        add(1,0,0,0,8'h00, 0,1,0, 2,0);
        add(1,0,0,0,8'h00, 0,1,0, 3,0);
        add(1,0,0,0,8'h00, 0,1,0, 4,0);
        add(1,0,1,0,8'h41, 0,1,1, 4,1);
        add(0,0,1,0,8'h42, 0,1,1, 4,1);
        add(0,0,1,0,8'h43, 0,1,1, 3,1);
        // 5: flush + drop with packet at pending=2 forwards it; overflow stays
        add(1,1,1,1,8'h51, 1,1,0, 2,1);
        add(0,0,1,1,8'h52, 1,1,0, 0,1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pending", 0, 32'(pending), 32'd0);
        chk("reset_overflow", 0, 32'(overflow), 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drop = vecs[i].drop; flush = vecs[i].flush;
            bus.in_val = vecs[i].in_val; bus.out_rdy = vecs[i].out_rdy; bus.in_msg = vecs[i].msg;
            @(negedge clk);
            $display("step %0d: drop=%0b flush=%0b val=%0b rdy=%0b msg=%02h -> out_val=%0b in_rdy=%0b dropped=%0b pending=%0d overflow=%0b",
                     i, drop, flush, bus.in_val, bus.out_rdy, bus.in_msg, bus.out_val, bus.in_rdy, dropped, pending, overflow);
            chk("out_val", i, 32'(bus.out_val), 32'(vecs[i].e_out_val));
            chk("in_rdy", i, 32'(bus.in_rdy), 32'(vecs[i].e_in_rdy));
            chk("dropped", i, 32'(dropped), 32'(vecs[i].e_dropped));
            chk("pending", i, 32'(pending), 32'(vecs[i].e_pend));
            chk("overflow", i, 32'(overflow), 32'(vecs[i].e_ovf));
            chk("out_msg", i, 32'(bus.out_msg), 32'(vecs[i].msg));
        end

        // 6: build pending=3, then pull reset low mid-cycle
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            drop = 1'b1; flush = 1'b0; bus.in_val = 1'b0; bus.out_rdy = 1'b1;
        end
        @(posedge clk); #1;
        drop = 1'b0;
        @(negedge clk);
        chk("pre_reset_pending", 100, 32'(pending), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        $display("async reset asserted: pending=%0d overflow=%0b", pending, overflow);
        chk("async_reset_pending", 101, 32'(pending), 32'd0);
        chk("async_reset_overflow", 101, 32'(overflow), 32'd0);
        drop = 1'b1; bus.in_val = 1'b1; bus.out_rdy = 1'b1; bus.in_msg = 8'h61;
        #1;
        chk("in_reset_out_val", 102, 32'(bus.out_val), 32'd1);
        chk("in_reset_dropped", 102, 32'(dropped), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; drop = 1'b0; bus.in_msg = 8'h62;
        @(negedge clk);
        $display("after release: out_val=%0b dropped=%0b out_msg=%02h pending=%0d", bus.out_val, dropped, bus.out_msg, pending);
        chk("post_reset_out_val", 103, 32'(bus.out_val), 32'd1);
        chk("post_reset_dropped", 103, 32'(dropped), 32'd0);
        chk("post_reset_out_msg", 103, 32'(bus.out_msg), 32'h62);
        chk("post_reset_pending", 103, 32'(pending), 32'd0);
        @(posedge clk); #1;
        bus.in_val = 1'b0;
        @(negedge clk);
        chk("post_reset_pending_hold", 104, 32'(pending), 32'd0);
        chk("post_reset_overflow", 104, 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
